// File: rtl/padlock_pkg.sv
// rtl/padlock_pkg.sv - shared FSM encoding and digit width for the padlock code entry
package padlock_pkg;

   localparam int DIGIT_W = 4;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ENTRY   = 2'd1;
   localparam logic [1:0] ST_GRANTED = 2'd2;
   localparam logic [1:0] ST_LOCKOUT = 2'd3;

endpackage

// File: rtl/padlock_debounce.sv
// rtl/padlock_debounce.sv - two-flop synchronizer followed by a stable-count debouncer
module padlock_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_i,
   output logic level_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   // Any sample that agrees with the current level restarts the run.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/padlock_code_entry.sv
// rtl/padlock_code_entry.sv - keypad code entry with attempt evaluation, grant window and lockout
module padlock_code_entry
   import padlock_pkg::*;
#(
   parameter int CODE_LEN = 4,
   parameter logic [CODE_LEN*DIGIT_W-1:0] CODE = 16'h1963,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int ENTRY_TIMEOUT = 256,
   parameter int GRANT_CYCLES = 32,
   parameter int MAX_FAILS = 3,
   parameter int LOCKOUT_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       but_0,
   input  logic       but_1,
   input  logic       but_2,
   input  logic       but_3,
   input  logic       but_4,
   input  logic       but_5,
   input  logic       but_6,
   input  logic       but_7,
   input  logic       but_8,
   input  logic       but_9,
   output logic       correct,
   output logic       lockout,
   output logic [2:0] digit_count,
   output logic [1:0] fail_count
);

   localparam int T_MAX = (LOCKOUT_CYCLES > GRANT_CYCLES)
                        ? ((LOCKOUT_CYCLES > ENTRY_TIMEOUT) ? LOCKOUT_CYCLES : ENTRY_TIMEOUT)
                        : ((GRANT_CYCLES > ENTRY_TIMEOUT) ? GRANT_CYCLES : ENTRY_TIMEOUT);
   localparam int TW = $clog2(T_MAX + 1);
   localparam logic [TW-1:0] ENTRY_LAST = TW'(ENTRY_TIMEOUT - 1);
   localparam logic [TW-1:0] GRANT_LAST = TW'(GRANT_CYCLES - 1);
   localparam logic [TW-1:0] LOCK_LAST  = TW'(LOCKOUT_CYCLES - 1);

   logic [9:0] buttons, level, level_prev_q, press_vec;
   logic [DIGIT_W-1:0] press_digit;
   logic [3:0] n_press;
   logic       any_press, bad_digit;

   logic [1:0]    state_q, state_d;
   logic [2:0]    digit_count_q, digit_count_d;
   logic [1:0]    fail_count_q, fail_count_d, fail_inc;
   logic [TW-1:0] timer_q, timer_d;
   logic          mismatch_q, mismatch_d;
   logic          eval_q, eval_d;

   function automatic logic [DIGIT_W-1:0] code_digit(input logic [2:0] idx);
      logic [CODE_LEN*DIGIT_W-1:0] sh;
      sh = CODE >> ((CODE_LEN - 1 - int'(idx)) * DIGIT_W);
      return sh[DIGIT_W-1:0];
   endfunction

   assign buttons = {but_9, but_8, but_7, but_6, but_5, but_4, but_3, but_2, but_1, but_0};

   for (genvar g = 0; g < 10; g++) begin : g_btn
      padlock_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk    (clk),
         .reset  (reset),
         .btn_i  (buttons[g]),
         .level_o(level[g])
      );
   end

   // Edge detection on the debounced level means a held key yields exactly one press.
   assign press_vec = level & ~level_prev_q;

   always_comb begin
      press_digit = '0;
      n_press     = '0;
      for (int i = 9; i >= 0; i--) begin
         if (press_vec[i]) begin
            press_digit = DIGIT_W'(i);
            n_press     = n_press + 4'd1;
         end
      end
   end

   assign any_press = (n_press != 4'd0);
   assign bad_digit = (n_press > 4'd1);
   assign fail_inc  = (fail_count_q == 2'b11) ? 2'b11 : fail_count_q + 2'd1;

   always_comb begin
      state_d       = state_q;
      digit_count_d = digit_count_q;
      fail_count_d  = fail_count_q;
      timer_d       = timer_q;
      mismatch_d    = mismatch_q;
      eval_d        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            timer_d = '0;
            if (any_press) begin
               state_d       = ST_ENTRY;
               digit_count_d = 3'd1;
               mismatch_d    = bad_digit || (press_digit != code_digit(3'd0));
               eval_d        = (CODE_LEN == 1);
            end
         end
         ST_ENTRY: begin
            if (eval_q) begin
               digit_count_d = '0;
               timer_d       = '0;
               if (!mismatch_q) begin
                  state_d      = ST_GRANTED;
                  fail_count_d = '0;
               end else begin
                  fail_count_d = fail_inc;
                  state_d      = (int'(fail_inc) >= MAX_FAILS) ? ST_LOCKOUT : ST_IDLE;
               end
            end else if (any_press) begin
               timer_d       = '0;
               digit_count_d = digit_count_q + 3'd1;
               mismatch_d    = mismatch_q || bad_digit || (press_digit != code_digit(digit_count_q));
               eval_d        = (int'(digit_count_q) + 1 == CODE_LEN);
            end else if (timer_q == ENTRY_LAST) begin
               state_d       = ST_IDLE;
               digit_count_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_GRANTED: begin
            timer_d = timer_q + 1'b1;
            if (timer_q == GRANT_LAST) begin
               state_d = ST_IDLE;
               timer_d = '0;
            end
         end
         default: begin
            timer_d = timer_q + 1'b1;
            if (timer_q == LOCK_LAST) begin
               state_d      = ST_IDLE;
               timer_d      = '0;
               fail_count_d = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         digit_count_q <= '0;
         fail_count_q  <= '0;
         timer_q       <= '0;
         mismatch_q    <= 1'b0;
         eval_q        <= 1'b0;
         level_prev_q  <= '0;
      end else begin
         state_q       <= state_d;
         digit_count_q <= digit_count_d;
         fail_count_q  <= fail_count_d;
         timer_q       <= timer_d;
         mismatch_q    <= mismatch_d;
         eval_q        <= eval_d;
         level_prev_q  <= level;
      end
   end

   assign correct     = (state_q == ST_GRANTED);
   assign lockout     = (state_q == ST_LOCKOUT);
   assign digit_count = digit_count_q;
   assign fail_count  = fail_count_q;

endmodule

// File: tb/tb_padlock_code_entry.sv
// tb/tb_padlock_code_entry.sv - directed self-checking bench for padlock_code_entry
module tb_padlock_code_entry;
   import padlock_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] but;
   logic       correct, lockout;
   logic [2:0] digit_count;
   logic [1:0] fail_count;

   int checks = 0;
   int errors = 0;
   int corr_cycles;
   int lock_cycles;
   int max_dc;

   always #5 clk = ~clk;

   padlock_code_entry dut (
      .clk(clk), .reset(reset),
      .but_0(but[0]), .but_1(but[1]), .but_2(but[2]), .but_3(but[3]), .but_4(but[4]),
      .but_5(but[5]), .but_6(but[6]), .but_7(but[7]), .but_8(but[8]), .but_9(but[9]),
      .correct(correct), .lockout(lockout), .digit_count(digit_count), .fail_count(fail_count)
   );

   task automatic tick();
      @(negedge clk);
      if (correct) corr_cycles++;
      if (lockout) lock_cycles++;
      if (int'(digit_count) > max_dc) max_dc = int'(digit_count);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic press_mask(input logic [9:0] mask, input int hold);
      but = mask;
      idle(hold);
      but = '0;
      idle(10);
   endtask

   task automatic press(input int idx);
      press_mask(10'(1) << idx, 10);
   endtask

   task automatic clear_stats();
      corr_cycles = 0;
      lock_cycles = 0;
      max_dc = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      but = '0;
      idle(3);
      reset = 1'b0;
      idle(2);
   endtask

   task automatic wrong_code();
      press(1); press(9); press(6); press(4);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({correct, lockout, digit_count, fail_count} !== 7'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 0000000", {correct, lockout, digit_count, fail_count});
      end
      checks++;
      if (dut.state_q !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_state: got %0d expected %0d", dut.state_q, ST_IDLE);
      end
   endtask

   task automatic test_correct_code();
      do_reset();
      clear_stats();
      press(1); press(9);
      checks++;
      if (digit_count !== 3'd2) begin
         errors++;
         $display("FAIL partial_digit_count: got %0d expected 2", digit_count);
      end
      press(6);
      press_mask(10'b00_0000_1000, 60);
      idle(20);
      checks++;
      if (corr_cycles != 32) begin
         errors++;
         $display("FAIL grant_length: got %0d cycles expected 32", corr_cycles);
      end
      checks++;
      if (fail_count !== 2'd0 || digit_count !== 3'd0) begin
         errors++;
         $display("FAIL grant_counts: got fail=%0d dc=%0d expected fail=0 dc=0", fail_count, digit_count);
      end
   endtask

   task automatic test_wrong_code();
      do_reset();
      clear_stats();
      wrong_code();
      idle(10);
      checks++;
      if (corr_cycles != 0 || fail_count !== 2'd1) begin
         errors++;
         $display("FAIL wrong_code: got correct_cycles=%0d fail=%0d expected 0 and 1", corr_cycles, fail_count);
      end
      checks++;
      if (dut.state_q !== ST_IDLE || digit_count !== 3'd0) begin
         errors++;
         $display("FAIL wrong_code_idle: got state=%0d dc=%0d expected %0d and 0", dut.state_q, digit_count, ST_IDLE);
      end
   endtask

   task automatic test_lockout();
      do_reset();
      wrong_code();
      wrong_code();
      clear_stats();
      wrong_code();
      checks++;
      if (lockout !== 1'b1 || fail_count !== 2'd3) begin
         errors++;
         $display("FAIL lockout_entry: got lockout=%b fail=%0d expected 1 and 3", lockout, fail_count);
      end
      press(1); press(9); press(6); press(3);
      idle(1000);
      checks++;
      if (lock_cycles != 1024) begin
         errors++;
         $display("FAIL lockout_length: got %0d cycles expected 1024", lock_cycles);
      end
      checks++;
      if (corr_cycles != 0 || fail_count !== 2'd0 || lockout !== 1'b0) begin
         errors++;
         $display("FAIL lockout_exit: got correct_cycles=%0d fail=%0d lockout=%b expected 0 0 0",
                  corr_cycles, fail_count, lockout);
      end
   endtask

   task automatic test_bounce();
      do_reset();
      clear_stats();
      for (int i = 0; i < 3; i++) begin
         but[1] = 1'b1; idle(2);
         but[1] = 1'b0; idle(2);
      end
      checks++;
      if (digit_count !== 3'd0) begin
         errors++;
         $display("FAIL bounce_filtered: got dc=%0d expected 0", digit_count);
      end
      press_mask(10'b00_0000_0010, 30);
      idle(20);
      checks++;
      if (digit_count !== 3'd1 || max_dc != 1) begin
         errors++;
         $display("FAIL bounce_single_press: got dc=%0d max=%0d expected 1 and 1", digit_count, max_dc);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      wrong_code();
      press(1); press(9);
      checks++;
      if (digit_count !== 3'd2) begin
         errors++;
         $display("FAIL timeout_pre: got dc=%0d expected 2", digit_count);
      end
      idle(300);
      checks++;
      if (digit_count !== 3'd0 || fail_count !== 2'd1 || dut.state_q !== ST_IDLE) begin
         errors++;
         $display("FAIL timeout: got dc=%0d fail=%0d state=%0d expected 0 1 %0d",
                  digit_count, fail_count, dut.state_q, ST_IDLE);
      end
   endtask

   task automatic test_simultaneous();
      clear_stats();
      press_mask(10'b10_0000_0010, 10);
      checks++;
      if (digit_count !== 3'd1) begin
         errors++;
         $display("FAIL multi_one_digit: got dc=%0d expected 1", digit_count);
      end
      press(9); press(6); press(3);
      idle(10);
      checks++;
      if (corr_cycles != 0 || fail_count !== 2'd2) begin
         errors++;
         $display("FAIL multi_invalid: got correct_cycles=%0d fail=%0d expected 0 and 2", corr_cycles, fail_count);
      end
   endtask

   task automatic test_reset_in_grant();
      int waited;
      do_reset();
      press(1); press(9); press(6);
      but[3] = 1'b1;
      waited = 0;
      while (correct !== 1'b1 && waited < 40) begin
         tick();
         waited++;
      end
      checks++;
      if (correct !== 1'b1) begin
         errors++;
         $display("FAIL grant_reached: got correct=%b expected 1", correct);
      end
      idle(5);
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({correct, lockout, digit_count, fail_count} !== 7'b0) begin
         errors++;
         $display("FAIL reset_in_grant: got %b expected 0000000", {correct, lockout, digit_count, fail_count});
      end
      but = '0;
      idle(3);
      reset = 1'b0;
      clear_stats();
      idle(60);
      checks++;
      if (corr_cycles != 0) begin
         errors++;
         $display("FAIL post_reset_grant: got %0d correct cycles expected 0", corr_cycles);
      end
   endtask

   initial begin
      reset = 1'b1;
      but = '0;
      clear_stats();
      test_reset();
      test_correct_code();
      test_wrong_code();
      test_lockout();
      test_bounce();
      test_timeout();
      test_simultaneous();
      test_reset_in_grant();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/padlock_code_entry.md
PADLOCK_CODE_ENTRY -- requirements
Module: padlock_code_entry

Interface
REQ-001 SHALL have parameter CODE_LEN, default 4, number of digits per code entry.
REQ-002 SHALL have parameter CODE, default 16'h1963, 4 bits per digit, first digit in the most significant nibble.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 4, number of stable cycles required before a debounced level changes.
REQ-004 SHALL have parameter ENTRY_TIMEOUT, default 256, maximum idle cycles allowed between digits.
REQ-005 SHALL have parameter GRANT_CYCLES, default 32, length of the correct window.
REQ-006 SHALL have parameter MAX_FAILS, default 3, number of consecutive failures that triggers lockout.
REQ-007 SHALL have parameter LOCKOUT_CYCLES, default 1024, lockout duration.
REQ-008 SHALL have port clk, input, 1 bit, single clock.
REQ-009 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-010 SHALL have ports but_0..but_9, input, 1 bit each, raw asynchronous keypad buttons, active-high.
REQ-011 SHALL have port correct, output, 1 bit, code accepted; consumed by the downstream lock stage.
REQ-012 SHALL have port lockout, output, 1 bit, entry disabled.
REQ-013 SHALL have port digit_count, output, 3 bits, digits entered in the current attempt.
REQ-014 SHALL have port fail_count, output, 2 bits, consecutive failures.

Function
REQ-015 SHALL synchronize each button through 2 flops, then debounce it: the debounced level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-016 SHALL define a press as a 0->1 transition of a debounced level; releases are ignored.
REQ-017 SHALL define one press cycle as a single press event: digit value = button index; two or more presses in the same cycle = one invalid digit.
REQ-018 SHALL implement FSM states IDLE, ENTRY, GRANTED, LOCKOUT.
REQ-019 SHALL behave as follows in IDLE: first press -> ENTRY, digit_count=1, mismatch flag = (digit != CODE digit 0).
REQ-020 SHALL behave as follows in ENTRY: each press increments digit_count and ORs its mismatch into the flag, comparing against digit index digit_count; an invalid digit sets mismatch.
REQ-021 SHALL evaluate the attempt in the cycle after the CODE_LEN-th press: no mismatch -> GRANTED, fail_count=0; mismatch -> fail_count+1, then LOCKOUT if fail_count reaches MAX_FAILS, else IDLE.
REQ-022 SHALL, in ENTRY with ENTRY_TIMEOUT cycles and no press, return to IDLE, clear digit_count, and leave fail_count unchanged.
REQ-023 SHALL hold correct=1 for exactly GRANT_CYCLES cycles in GRANTED, then return to IDLE; presses during GRANTED are ignored.
REQ-024 SHALL hold lockout=1 for exactly LOCKOUT_CYCLES cycles in LOCKOUT, ignore presses, then go to IDLE with fail_count=0.
REQ-025 SHALL clear digit_count on every return to IDLE.
REQ-026 SHALL saturate fail_count and never let it wrap.
REQ-027 SHALL count a button held down across a state change only once and never generate a repeat press.

Reset
REQ-028 SHALL, on reset assertion, immediately force FSM=IDLE, correct=0, lockout=0, digit_count=0, fail_count=0, all counters=0, and all sync/debounce flops=0.
REQ-029 SHALL, on reset mid-entry, mid-grant, or mid-lockout, abandon the operation without emitting a correct pulse.

Structure
REQ-030 SHALL place the FSM state encoding and the digit-width constant (4) in a shared padlock package.
REQ-031 SHALL implement synchronizer plus debounce as one sub-module, padlock_debounce, instantiated 10 times.

Verification
REQ-032 SHALL verify: presses 1,9,6,3 spaced 20 cycles -> correct=1 for 32 cycles, fail_count=0.
REQ-033 SHALL verify: presses 1,9,6,4 -> correct stays 0, fail_count=1, FSM in IDLE.
REQ-034 SHALL verify: three wrong 4-digit codes -> lockout=1 for 1024 cycles; a correct code entered during lockout -> no correct; afterwards fail_count=0.
REQ-035 SHALL verify: button 1 bouncing 3 times with 2-cycle pulses, then held -> exactly one press, digit_count=1.
REQ-036 SHALL verify: presses 1,9, then 300 idle cycles -> digit_count=0, fail_count unchanged; buttons 1 and 9 pressed simultaneously as the first digit, followed by three further presses -> failure.
REQ-037 SHALL verify: reset asserted during GRANTED -> correct=0 immediately, all outputs at reset values.
